tinycpu_ctrl: RTL

Control unit for the tinycpu stack machine. It owns the four-phase instruction state machine (IDLE, FETCHA, FETCHB, EXECA, EXECB) and decodes the instruction register into the per-cycle datapath strobes. These strobes drive the PC and IR counters, the stack, the RAM, the output buffer and the abus/dbus source selects. It sits beside the datapath inside the CPU top level and replaces the separate state module plus the inline decode block.

---
 rtl/tinycpu_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tinycpu_ctrl.sv
// rtl/tinycpu_ctrl.sv - tinycpu control unit: instruction phase FSM plus datapath strobe decode
// Strobes are combinational from (cs, ir, qtop) and are forced low while reset is high.
module tinycpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [15:0] qtop,
  output logic [2:0]  cs,
  output logic        halted,
  output logic        pcinc,
  output logic        abus2pc,
  output logic        dbus2ir,
  output logic        push,
  output logic        pop,
  output logic        dbus2qtop,
  output logic        dbus2ram,
  output logic        dbus2obuf,
  output logic        pc2abus,
  output logic        ir2abus,
  output logic        ir2dbus,
  output logic        qtop2dbus,
  output logic        alu2dbus,
  output logic        ram2dbus,
  output logic        in2dbus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCHA = 3'd1,
    FETCHB = 3'd2,
    EXECA  = 3'd3,
    EXECB  = 3'd4
  } state_e;

  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_PUSH  = 4'd2;
  localparam logic [3:0] OP_POP   = 4'd3;
  localparam logic [3:0] OP_JMP   = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JNZ   = 4'd6;
  localparam logic [3:0] OP_IN    = 4'd13;
  localparam logic [3:0] OP_OUT   = 4'd14;
  localparam logic [3:0] OP_OP    = 4'd15;

  state_e     state_q;
  logic       halted_q;
  logic [3:0] opcode;
  logic       op_halts;
  logic       qtop_zero;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign qtop_zero = (qtop == 16'h0000);
  assign unused_ir = ^{ir[11:5], ir[3:0]};

  // HALT and every unassigned opcode end the run.
  always_comb begin
    op_halts = 1'b1;
    case (opcode)
      OP_PUSHI, OP_PUSH, OP_POP, OP_JMP, OP_JZ, OP_JNZ,
      OP_IN, OP_OUT, OP_OP: op_halts = 1'b0;
      default:              op_halts = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q  <= FETCHA;
            halted_q <= 1'b0;
          end
        end
        FETCHA: state_q <= FETCHB;
        FETCHB: state_q <= EXECA;
        EXECA: begin
          if (opcode == OP_PUSH) begin
            state_q <= EXECB;
          end else if (op_halts) begin
            state_q  <= IDLE;
            halted_q <= 1'b1;
          end else begin
            state_q <= FETCHA;
          end
        end
        EXECB:   state_q <= FETCHA;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs     = state_q;
  assign halted = halted_q;

  always_comb begin
    pcinc     = 1'b0;
    abus2pc   = 1'b0;
    dbus2ir   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    dbus2qtop = 1'b0;
    dbus2ram  = 1'b0;
    dbus2obuf = 1'b0;
    pc2abus   = 1'b0;
    ir2abus   = 1'b0;
    ir2dbus   = 1'b0;
    qtop2dbus = 1'b0;
    alu2dbus  = 1'b0;
    ram2dbus  = 1'b0;
    in2dbus   = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCHA: begin
          pc2abus = 1'b1;
          pcinc   = 1'b1;
        end
        FETCHB: begin
          ram2dbus = 1'b1;
          dbus2ir  = 1'b1;
        end
        EXECA: begin
          case (opcode)
            OP_PUSHI: begin
              ir2dbus   = 1'b1;
              dbus2qtop = 1'b1;
              push      = 1'b1;
            end
            OP_PUSH: ir2abus = 1'b1;
            OP_POP: begin
              ir2abus   = 1'b1;
              qtop2dbus = 1'b1;
              dbus2ram  = 1'b1;
              pop       = 1'b1;
            end
            OP_JMP: begin
              ir2abus = 1'b1;
              abus2pc = 1'b1;
            end
            OP_JZ: begin
              pop     = 1'b1;
              ir2abus = qtop_zero;
              abus2pc = qtop_zero;
            end
            OP_JNZ: begin
              pop     = 1'b1;
              ir2abus = !qtop_zero;
              abus2pc = !qtop_zero;
            end
            OP_IN: begin
              in2dbus   = 1'b1;
              dbus2qtop = 1'b1;
              push      = 1'b1;
            end
            OP_OUT: begin
              qtop2dbus = 1'b1;
              dbus2obuf = 1'b1;
              pop       = 1'b1;
            end
            // ir[4] marks unary ALU ops that reuse the top slot without popping.
            OP_OP: begin
              alu2dbus  = 1'b1;
              dbus2qtop = 1'b1;
              pop       = !ir[4];
            end
            default: ;
          endcase
        end
        EXECB: begin
          ram2dbus  = 1'b1;
          dbus2qtop = 1'b1;
          push      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
